fpu_io_bridge: RTL and testbench

//  Byte-serial GPIO front/back end for the FPU core inside fpu_wrapper.
//  - Receives an opcode and two 32-bit operands from off-chip pads.
//  - Issues them to the FPU over a valid/ready handshake.
//  - Captures the result and flags, then returns them byte-serially on the pads.
//  - Pad inputs are asynchronous to the system clock; all of them are synchronized here.

---
 rtl/fpu_io_bridge_if.sv | 23 ++
 rtl/fpu_io_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_fpu_io_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_io_bridge_if.sv
// FPU request/result bundle between fpu_io_bridge (master) and the FPU core (slave).
//  fpu_valid_o / fpu_ready_i : request handshake, carrying fpu_op_o, fpu_a_o, fpu_b_o
//  fpu_res_valid_i           : one-cycle result strobe, carrying fpu_res_i, fpu_flags_i
interface fpu_io_bridge_if ();
  logic        fpu_valid_o;
  logic        fpu_ready_i;
  logic [2:0]  fpu_op_o;
  logic [31:0] fpu_a_o;
  logic [31:0] fpu_b_o;
  logic        fpu_res_valid_i;
  logic [31:0] fpu_res_i;
  logic [4:0]  fpu_flags_i;

  modport master (
    output fpu_valid_o, fpu_op_o, fpu_a_o, fpu_b_o,
    input  fpu_ready_i, fpu_res_valid_i, fpu_res_i, fpu_flags_i
  );

  modport slave (
    input  fpu_valid_o, fpu_op_o, fpu_a_o, fpu_b_o,
    output fpu_ready_i, fpu_res_valid_i, fpu_res_i, fpu_flags_i
  );
endinterface

// File: rtl/fpu_io_bridge.sv
// Byte-serial pad front/back end for the FPU core.
//  wb_clk_i, wb_rst_i : system clock, async active-high reset
//  rx_data_i/rx_stb_i/rx_frm_i : async pad byte, strobe (rising edge = byte), frame enable
//  tx_ack_i            : async pad ack (rising edge consumes one tx byte)
//  tx_data_o/tx_valid_o: result byte to host
//  busy_o, ovr_o       : frame/op in progress, sticky dropped-strobe flag
//  fpu                 : request/result bundle to the FPU (master side)
// Frame: opcode byte, A (4 bytes MSB first), B (4 bytes MSB first).
// Reply: res[31:24], res[23:16], res[15:8], res[7:0], {timeout, 2'b00, flags}.
module fpu_io_bridge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_stb_i,
  input  logic                 rx_frm_i,
  input  logic                 tx_ack_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  output logic                 busy_o,
  output logic                 ovr_o,
  fpu_io_bridge_if.master      fpu
);

  localparam int unsigned TW      = $clog2(TIMEOUT);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_RX, S_ISSUE, S_WAIT, S_TX} state_t;

  // Pad synchronizers plus one edge-detect flop per strobe/ack
  logic [SYNC_STAGES-1:0] stb_sync, frm_sync, ack_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   stb_prev, ack_prev;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stb_sync <= '0;
      frm_sync <= '0;
      ack_sync <= '0;
      stb_prev <= 1'b0;
      ack_prev <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync[i] <= '0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], rx_stb_i};
      frm_sync <= {frm_sync[SYNC_STAGES-2:0], rx_frm_i};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack_i};
      stb_prev <= stb_sync[SYNC_STAGES-1];
      ack_prev <= ack_sync[SYNC_STAGES-1];
      data_sync[0] <= rx_data_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync[i] <= data_sync[i-1];
    end
  end

  logic       stb_edge_c, ack_edge_c, frm_c;
  logic [7:0] data_c;

  // Data sits in a chain of equal depth, so it lines up with the detected strobe edge
  assign stb_edge_c = stb_sync[SYNC_STAGES-1] & ~stb_prev;
  assign ack_edge_c = ack_sync[SYNC_STAGES-1] & ~ack_prev;
  assign frm_c      = frm_sync[SYNC_STAGES-1];
  assign data_c     = data_sync[SYNC_STAGES-1];

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [2:0]         op_q, op_n;
  logic [31:0]        a_q, a_n, b_q, b_n;
  logic               valid_q, valid_n;
  logic [TW-1:0]      timer_q, timer_n;
  logic [31:0]        res_q, res_n;
  logic [4:0]         flags_q, flags_n;
  logic               tmo_q, tmo_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [7:0]         txd_q, txd_n;
  logic               txv_q, txv_n;
  logic               ovr_q, ovr_n;
  logic               busy_q, busy_n;

  // Byte idx of the reply frame
  function automatic logic [7:0] reply_byte(input logic [IDX_W-1:0] idx,
                                            input logic [31:0] r,
                                            input logic [7:0] status);
    logic [7:0] b;
    case (idx)
      IDX_W'(0): b = r[31:24];
      IDX_W'(1): b = r[23:16];
      IDX_W'(2): b = r[15:8];
      IDX_W'(3): b = r[7:0];
      default:   b = status;
    endcase
    return b;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    valid_n = valid_q;
    timer_n = timer_q;
    res_n   = res_q;
    flags_n = flags_q;
    tmo_n   = tmo_q;
    idx_n   = idx_q;
    txd_n   = txd_q;
    txv_n   = txv_q;
    ovr_n   = ovr_q;

    case (state_q)
      S_RX: begin
        if (!frm_c) begin
          cnt_n = '0;
        end else if (stb_edge_c) begin
          // Operands shift in MSB first; four shifts fully replace any stale bytes
          if (cnt_q == CNT_W'(0))      op_n = data_c[2:0];
          else if (cnt_q <= CNT_W'(4)) a_n  = {a_q[23:0], data_c};
          else                         b_n  = {b_q[23:0], data_c};
          if (cnt_q == CNT_W'(8)) begin
            cnt_n   = '0;
            state_n = S_ISSUE;
            valid_n = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ISSUE: begin
        if (fpu.fpu_ready_i) begin
          valid_n = 1'b0;
          timer_n = '0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_n = timer_q + TW'(1);
        // A result arriving on the last timer cycle still takes priority
        if (fpu.fpu_res_valid_i) begin
          res_n   = fpu.fpu_res_i;
          flags_n = fpu.fpu_flags_i;
          tmo_n   = 1'b0;
          idx_n   = '0;
          txd_n   = fpu.fpu_res_i[31:24];
          txv_n   = 1'b1;
          state_n = S_TX;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_n   = QNAN;
          flags_n = '0;
          tmo_n   = 1'b1;
          idx_n   = '0;
          txd_n   = QNAN[31:24];
          txv_n   = 1'b1;
          state_n = S_TX;
        end
      end
      S_TX: begin
        if (ack_edge_c) begin
          if (idx_q == IDX_W'(4)) begin
            txv_n   = 1'b0;
            txd_n   = '0;
            cnt_n   = '0;
            state_n = S_RX;
          end else begin
            idx_n = idx_q + IDX_W'(1);
            txd_n = reply_byte(idx_q + IDX_W'(1), res_q, {tmo_q, 2'b00, flags_q});
          end
        end
      end
      default: state_n = S_RX;
    endcase

    // Strobes outside RX are dropped and flagged
    if (stb_edge_c && (state_q != S_RX)) ovr_n = 1'b1;

    busy_n = (state_n != S_RX) || (cnt_n != CNT_W'(0));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_RX;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      timer_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
      tmo_q   <= 1'b0;
      idx_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      valid_q <= valid_n;
      timer_q <= timer_n;
      res_q   <= res_n;
      flags_q <= flags_n;
      tmo_q   <= tmo_n;
      idx_q   <= idx_n;
      txd_q   <= txd_n;
      txv_q   <= txv_n;
      ovr_q   <= ovr_n;
      busy_q  <= busy_n;
    end
  end

  assign tx_data_o       = txd_q;
  assign tx_valid_o      = txv_q;
  assign busy_o          = busy_q;
  assign ovr_o           = ovr_q;
  assign fpu.fpu_valid_o = valid_q;
  assign fpu.fpu_op_o    = op_q;
  assign fpu.fpu_a_o     = a_q;
  assign fpu.fpu_b_o     = b_q;

endmodule

// File: tb/tb_fpu_io_bridge.sv
// Self-checking bench for fpu_io_bridge: table of frames plus hand-written
// sequences for partial frames, overrun and mid-TX reset.
module tb_fpu_io_bridge;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_stb, rx_frm, tx_ack;
  logic [7:0] tx_data;
  logic       tx_valid, busy, ovr;

  always #5 clk = ~clk;

  fpu_io_bridge_if fif ();

  fpu_io_bridge #(.SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .rx_data_i  (rx_data),
    .rx_stb_i   (rx_stb),
    .rx_frm_i   (rx_frm),
    .tx_ack_i   (tx_ack),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .busy_o     (busy),
    .ovr_o      (ovr),
    .fpu        (fif)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    logic [7:0]  opb;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
    int          stall;
    int          dly;
    bit          tmo;
  } vec_t;

  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  int         nvec = 0;
  int         nerr = 0;
  int         hs_cnt = 0;

  always @(posedge clk)
    if (!rst && fif.fpu_valid_o && fif.fpu_ready_i) hs_cnt++;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    cyc(SYNC + 2);
    rx_stb = 1'b1;
    cyc(3);
    rx_stb = 1'b0;
    cyc(2);
  endtask

  task automatic send_frame(input logic [7:0] opb, input logic [31:0] a, input logic [31:0] b);
    send_byte(opb);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
  endtask

  task automatic push_reply(input logic [31:0] r, input logic [7:0] status);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(r[8*i +: 8]);
    exp_tx.push_back(status);
  endtask

  // Wait for a request, optionally stall it, then accept exactly once
  task automatic fpu_accept(input int stall);
    int   k;
    logic stable;
    req_t snap, e;
    int   h0;
    k = 0;
    while (!fif.fpu_valid_o && k < 300) begin cyc(1); k++; end
    check("issue_valid", 64'(fif.fpu_valid_o), 64'd1);
    snap = '{fif.fpu_op_o, fif.fpu_a_o, fif.fpu_b_o};
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      cyc(1);
      if (!fif.fpu_valid_o || (req_t'({fif.fpu_op_o, fif.fpu_a_o, fif.fpu_b_o}) !== snap)) stable = 1'b0;
    end
    if (stall > 0) check("stall_stable", 64'(stable), 64'd1);
    h0 = hs_cnt;
    fif.fpu_ready_i = 1'b1;
    cyc(1);
    fif.fpu_ready_i = 1'b0;
    check("handshakes", 64'(hs_cnt - h0), 64'd1);
    check("valid_drop", 64'(fif.fpu_valid_o), 64'd0);
    if (exp_req.size() == 0) begin
      check("req_queue", 64'd0, 64'd1);
    end else begin
      e = exp_req.pop_front();
      check("fpu_op", 64'(snap.op), 64'(e.op));
      check("fpu_a",  64'(snap.a),  64'(e.a));
      check("fpu_b",  64'(snap.b),  64'(e.b));
    end
  endtask

  task automatic fpu_respond(input logic [31:0] r, input logic [4:0] f, input int dly);
    push_reply(r, {3'b000, f});
    cyc(dly);
    fif.fpu_res_i       = r;
    fif.fpu_flags_i     = f;
    fif.fpu_res_valid_i = 1'b1;
    cyc(1);
    fif.fpu_res_valid_i = 1'b0;
  endtask

  // Host side: consume n reply bytes against the scoreboard
  task automatic host_rx(input int n);
    int         k;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!tx_valid && k < int'(TMO) + 200) begin cyc(1); k++; end
      if (!tx_valid) begin
        check("tx_valid_wait", 64'(tx_valid), 64'd1);
        return;
      end
      e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
      check($sformatf("tx_byte%0d", i), 64'(tx_data), 64'(e));
      tx_ack = 1'b1;
      cyc(3);
      tx_ack = 1'b0;
      cyc(3);
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_req.push_back('{v.op, v.a, v.b});
    send_frame(v.opb, v.a, v.b);
    fpu_accept(v.stall);
    if (v.tmo) push_reply(32'h7FC0_0000, 8'h80);
    else       fpu_respond(v.res, v.flg, v.dly);
    host_rx(5);
    cyc(2);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_txv",  64'(tx_valid), 64'd0);
  endtask

  function automatic logic [77:0] outs();
    return {tx_data, tx_valid, busy, ovr, fif.fpu_valid_o, fif.fpu_op_o, fif.fpu_a_o, fif.fpu_b_o};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  vec_t tbl[5];
  vec_t v;

  initial begin
    tbl[0] = '{8'h01, 3'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'h00, 0,  3,       1'b0};
    tbl[1] = '{8'hFA, 3'd2, 32'hC049_0FDB, 32'h0000_0000, 32'h7F80_0000, 5'h0A, 0,  5,       1'b0};
    tbl[2] = '{8'h0F, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 5'h1F, 20, 1,       1'b0};
    tbl[3] = '{8'h03, 3'd3, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_0000, 5'h00, 0,  0,       1'b1};
    tbl[4] = '{8'h84, 3'd4, 32'h0000_0001, 32'h8000_0000, 32'h0123_4567, 5'h11, 2,  TMO - 1, 1'b0};

    rst = 1'b1;
    rx_data = '0; rx_stb = 1'b0; rx_frm = 1'b0; tx_ack = 1'b0;
    fif.fpu_ready_i = 1'b0; fif.fpu_res_valid_i = 1'b0;
    fif.fpu_res_i = '0; fif.fpu_flags_i = '0;
    cyc(3);
    check("reset_outs", 64'(outs() != 78'd0), 64'd0);
    rst = 1'b0;
    rx_frm = 1'b1;
    cyc(SYNC + 2);
    check("post_reset_outs", 64'(outs() != 78'd0), 64'd0);

    for (int i = 0; i < 5; i++) run_op(tbl[i]);
    check("total_handshakes", 64'(hs_cnt), 64'd5);
    check("ovr_clean", 64'(ovr), 64'd0);

    // Partial frame discarded, next full frame issued alone
    send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
    check("partial_busy", 64'(busy), 64'd1);
    rx_frm = 1'b0;
    cyc(SYNC + 3);
    check("frame_drop_idle", 64'(busy), 64'd0);
    rx_frm = 1'b1;
    cyc(SYNC + 2);
    v = '{8'h05, 3'd5, 32'h1122_3344, 32'h5566_7788, 32'h3C00_0000, 5'h01, 0, 3, 1'b0};
    run_op(v);
    check("drop_handshakes", 64'(hs_cnt), 64'd6);

    // Stray strobe while waiting for the result
    exp_req.push_back('{3'd6, 32'hCAFE_F00D, 32'h0BAD_BEEF});
    send_frame(8'h06, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    fpu_accept(0);
    check("ovr_before", 64'(ovr), 64'd0);
    send_byte(8'hEE);
    check("ovr_set", 64'(ovr), 64'd1);
    fpu_respond(32'hC2F6_E979, 5'h04, 2);
    host_rx(5);
    cyc(2);
    check("ovr_sticky", 64'(ovr), 64'd1);
    check("ovr_handshakes", 64'(hs_cnt), 64'd7);

    // Reset asserted mid-TX after two acks
    exp_req.push_back('{3'd0, 32'h4049_0FDB, 32'h402D_F854});
    send_frame(8'h00, 32'h4049_0FDB, 32'h402D_F854);
    fpu_accept(0);
    fpu_respond(32'h4108_A2C0, 5'h01, 4);
    host_rx(2);
    #2 rst = 1'b1;
    #1 check("async_reset_outs", 64'(outs() != 78'd0), 64'd0);
    exp_tx.delete();
    cyc(2);
    check("reset_hold_outs", 64'(outs() != 78'd0), 64'd0);
    rst = 1'b0;
    cyc(SYNC + 3);
    check("after_reset_txv", 64'(tx_valid), 64'd0);
    v = '{8'h02, 3'd2, 32'h3F00_0000, 32'h3E80_0000, 32'h3E00_0000, 5'h00, 0, 6, 1'b0};
    run_op(v);
    check("final_handshakes", 64'(hs_cnt), 64'd9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
